// File: rtl/comgen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : comgen_pkg                                                |
// | Purpose  : Opcodes, FSM states and field widths of the command gen.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package comgen_pkg;

   localparam logic [1:0] OP_TILE = 2'b01;
   localparam logic [1:0] OP_TRI  = 2'b10;
   localparam logic [1:0] OP_VERT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TILE = 2'd1,
      VERT = 2'd2,
      TRI  = 2'd3
   } state_t;

   localparam int XY_W       = 6;
   localparam int Z_W        = 10;
   localparam int R_W        = 5;
   localparam int G_W        = 6;
   localparam int B_W        = 5;
   localparam int VERT_BYTES = 6;
   localparam int VERT_W     = 2 + 2 + 6 + 2*XY_W + Z_W + R_W + G_W + B_W;

endpackage
`default_nettype wire

// File: rtl/comgen_vertex_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : comgen_vertex_fmt                                         |
// | Purpose  : Packs one quad corner into the 48-bit vertex command.     |
// |            COMGEN_ANIM_EN: colour fields XORed with frame_cnt.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module comgen_vertex_fmt
   import comgen_pkg::*;
#(
   parameter logic [Z_W-1:0] Z_BASE = 10'h200,
   parameter logic [Z_W-1:0] Z_STEP = 10'h010
) (
   input  logic [1:0]        slot,
   input  logic [3:0]        q,
   input  logic [3:0]        id_x,
   input  logic [2:0]        id_y,
   input  logic [7:0]        frame_cnt,
   output logic [VERT_W-1:0] vert
);

   logic [XY_W-1:0] w_near;
   logic [XY_W-1:0] w_far;
   logic [XY_W-1:0] w_x;
   logic [XY_W-1:0] w_y;
   logic [Z_W-1:0]  w_z;
   logic [R_W-1:0]  w_r;
   logic [G_W-1:0]  w_g;
   logic [B_W-1:0]  w_b;
   logic            w_unused_fc;

   always_comb begin
      w_near = {2'b00, q};
      w_far  = 6'd32 - w_near;
      // slot bit 0 selects the far x edge, bit 1 the far y edge
      w_x    = slot[0] ? w_far : w_near;
      w_y    = slot[1] ? w_far : w_near;
      w_z    = Z_BASE - ({6'd0, q} * Z_STEP);
      w_r    = {id_x, 1'b0};
      w_g    = {q[2:0], 3'b000};
      w_b    = {id_y, 2'b00};
`ifdef COMGEN_ANIM_EN
      w_r    = w_r ^ frame_cnt[4:0];
      w_g    = w_g ^ frame_cnt[5:0];
      w_b    = w_b ^ frame_cnt[4:0];
`endif
      vert   = {OP_VERT, slot, 6'h00, w_x, w_y, w_z, w_r, w_g, w_b};
   end

`ifdef COMGEN_ANIM_EN
   assign w_unused_fc = ^frame_cnt[7:6];
`else
   assign w_unused_fc = ^frame_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/comgen_scene.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : comgen_scene                                              |
// | Purpose  : Tile/vertex/triangle test-stream generator, one byte per  |
// |            cycle into the rasteriser FIFO. Option: COMGEN_ANIM_EN.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module comgen_scene
   import comgen_pkg::*;
#(
   parameter int             TILES_X        = 10,
   parameter int             TILES_Y        = 8,
   parameter int             QUADS_PER_TILE = 2,
   parameter logic [Z_W-1:0] Z_BASE         = 10'h200,
   parameter logic [Z_W-1:0] Z_STEP         = 10'h010,
   parameter bit             LOOP           = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [7:0] frame_cnt,
   output logic [7:0] command_wrdata,
   output logic       command_push,
   input  logic       command_full
);

   localparam logic [3:0] c_last_x = 4'(TILES_X - 1);
   localparam logic [2:0] c_last_y = 3'(TILES_Y - 1);
   localparam logic [3:0] c_last_q = 4'(QUADS_PER_TILE - 1);

   state_t      r_state, w_state;
   logic [3:0]  r_id_x, w_id_x;
   logic [2:0]  r_id_y, w_id_y;
   logic [3:0]  r_q, w_q;
   logic [1:0]  r_slot, w_slot;
   logic [2:0]  r_byte, w_byte;
   logic [7:0]  r_frame_cnt;
   logic [15:0] w_tile_word;
   logic [VERT_W-1:0] w_vert;

   comgen_vertex_fmt #(
      .Z_BASE (Z_BASE),
      .Z_STEP (Z_STEP)
   ) u_vertex_fmt (
      .slot      (r_slot),
      .q         (r_q),
      .id_x      (r_id_x),
      .id_y      (r_id_y),
      .frame_cnt (r_frame_cnt),
      .vert      (w_vert)
   );

   assign busy         = (r_state != IDLE);
   assign command_push = busy & ~command_full;
   assign frame_cnt    = r_frame_cnt;
   assign w_tile_word  = {OP_TILE, 7'h00, r_id_y, r_id_x};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_id_x      <= '0;
         r_id_y      <= '0;
         r_q         <= '0;
         r_slot      <= '0;
         r_byte      <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_state <= w_state;
         r_id_x  <= w_id_x;
         r_id_y  <= w_id_y;
         r_q     <= w_q;
         r_slot  <= w_slot;
         r_byte  <= w_byte;
         if (done)
            r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

   always_comb begin
      w_state = r_state;
      w_id_x  = r_id_x;
      w_id_y  = r_id_y;
      w_q     = r_q;
      w_slot  = r_slot;
      w_byte  = r_byte;
      done    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state = TILE;
               w_id_x  = '0;
               w_id_y  = '0;
               w_q     = '0;
               w_slot  = '0;
               w_byte  = '0;
            end
         end
         TILE: begin
            if (command_push) begin
               if (r_byte == 3'd1) begin
                  w_state = VERT;
                  w_byte  = '0;
                  w_q     = '0;
                  w_slot  = '0;
               end else begin
                  w_byte = r_byte + 3'd1;
               end
            end
         end
         VERT: begin
            if (command_push) begin
               if (r_byte == 3'(VERT_BYTES - 1)) begin
                  w_byte = '0;
                  if (r_slot == 2'd3) begin
                     w_state = TRI;
                     w_slot  = '0;
                  end else begin
                     w_slot = r_slot + 2'd1;
                  end
               end else begin
                  w_byte = r_byte + 3'd1;
               end
            end
         end
         TRI: begin
            if (command_push) begin
               if (r_byte == 3'd0) begin
                  w_byte = 3'd1;
               end else begin
                  w_byte = '0;
                  if (r_q != c_last_q) begin
                     w_q     = r_q + 4'd1;
                     w_state = VERT;
                  end else begin
                     w_q     = '0;
                     w_state = TILE;
                     if (r_id_x != c_last_x) begin
                        w_id_x = r_id_x + 4'd1;
                     end else begin
                        w_id_x = '0;
                        if (r_id_y != c_last_y) begin
                           w_id_y = r_id_y + 3'd1;
                        end else begin
                           // last byte of the frame
                           w_id_y  = '0;
                           done    = 1'b1;
                           w_state = LOOP ? TILE : IDLE;
                        end
                     end
                  end
               end
            end
         end
         default: w_state = IDLE;
      endcase
   end

   always_comb begin
      command_wrdata = 8'h00;
      case (r_state)
         TILE: command_wrdata = (r_byte == 3'd0) ? w_tile_word[15:8] : w_tile_word[7:0];
         VERT: begin
            case (r_byte)
               3'd0:    command_wrdata = w_vert[47:40];
               3'd1:    command_wrdata = w_vert[39:32];
               3'd2:    command_wrdata = w_vert[31:24];
               3'd3:    command_wrdata = w_vert[23:16];
               3'd4:    command_wrdata = w_vert[15:8];
               3'd5:    command_wrdata = w_vert[7:0];
               default: command_wrdata = 8'h00;
            endcase
         end
         TRI: command_wrdata = (r_byte == 3'd0) ? {OP_TRI, 2'd0, 2'd1, 2'd2}
                                                : {OP_TRI, 2'd1, 2'd2, 2'd3};
         default: command_wrdata = 8'h00;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_comgen_scene.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_comgen_scene                                           |
// | Purpose  : Self-checking bench for comgen_scene (three configs).     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_comgen_scene;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic full_a = 1'b0, full_b = 1'b0, full_c = 1'b0;
   logic busy_a, busy_b, busy_c;
   logic done_a, done_b, done_c;
   logic push_a, push_b, push_c;
   logic [7:0] fc_a, fc_b, fc_c;
   logic [7:0] wr_a, wr_b, wr_c;

   int n_tests = 0;
   int n_fail  = 0;
   int idx[3];
   int frames[3];
   int pushes[3];
   logic [7:0] cap_a[56];
   logic [7:0] cap_b[4320];
   bit stall_en = 1'b0;

   always #5 clk = ~clk;

   comgen_scene #(.TILES_X(2), .TILES_Y(1), .QUADS_PER_TILE(1), .LOOP(1'b0)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
      .frame_cnt(fc_a), .command_wrdata(wr_a), .command_push(push_a), .command_full(full_a));
   comgen_scene #(.TILES_X(10), .TILES_Y(8), .QUADS_PER_TILE(2), .LOOP(1'b0)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
      .frame_cnt(fc_b), .command_wrdata(wr_b), .command_push(push_b), .command_full(full_b));
   comgen_scene #(.TILES_X(1), .TILES_Y(1), .QUADS_PER_TILE(1), .LOOP(1'b1)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
      .frame_cnt(fc_c), .command_wrdata(wr_c), .command_push(push_c), .command_full(full_c));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Byte n of a frame derived from position arithmetic (default Z_BASE/Z_STEP).
   function automatic logic [7:0] exp_byte(input int tx, input int qp, input int n, input int fc);
      int bpt, tile, off, x, y, r, q, s, b, xi, yi, z, rr, gg, bb;
      logic [15:0] w16;
      logic [47:0] v;
      bpt  = 2 + 26*qp;
      tile = n / bpt;
      off  = n % bpt;
      x    = tile % tx;
      y    = tile / tx;
      if (off < 2) begin
         w16 = {2'b01, 7'h00, 3'(y), 4'(x)};
         return (off == 0) ? w16[15:8] : w16[7:0];
      end
      r = off - 2;
      q = r / 26;
      r = r % 26;
      if (r == 24) return 8'h86;
      if (r == 25) return 8'h9B;
      s  = r / 6;
      b  = r % 6;
      xi = (s % 2 == 1) ? 32 - q : q;
      yi = (s / 2 == 1) ? 32 - q : q;
      z  = (512 - 16*q) & 1023;
      rr = (x % 16) * 2;
      gg = (q % 8) * 8;
      bb = (y % 8) * 4;
`ifdef COMGEN_ANIM_EN
      rr = rr ^ (fc % 32);
      gg = gg ^ (fc % 64);
      bb = bb ^ (fc % 32);
`endif
      v = {2'b11, 2'(s), 6'd0, 6'(xi), 6'(yi), 10'(z), 5'(rr), 6'(gg), 5'(bb)};
      return 8'(v >> (8*(5-b)));
   endfunction

   task automatic model_step(input int k, input int tx, input int ty, input int qp,
                             input logic busy, input logic done, input logic push,
                             input logic full, input logic [7:0] wr, input logic [7:0] fc);
      int len;
      len = tx * ty * (2 + 26*qp);
      if (rst) begin
         idx[k]    = 0;
         frames[k] = 0;
         return;
      end
      check($sformatf("frame_cnt[%0d]", k), fc, 8'(frames[k]));
      check($sformatf("push_rule[%0d]", k), push, busy & ~full);
      check($sformatf("done[%0d] byte %0d", k, idx[k]), done, busy && push && idx[k] == len-1);
      check($sformatf("wrdata[%0d] byte %0d", k, idx[k]), wr,
            busy ? exp_byte(tx, qp, idx[k], frames[k]) : 8'h00);
      if (push) begin
         if (k == 0) cap_a[idx[k]] = wr;
         if (k == 1) cap_b[idx[k]] = wr;
         pushes[k]++;
         idx[k]++;
         if (idx[k] == len) begin
            idx[k] = 0;
            frames[k]++;
         end
      end
   endtask

   always @(negedge clk) begin
      model_step(0, 2, 1, 1, busy_a, done_a, push_a, full_a, wr_a, fc_a);
      model_step(1, 10, 8, 2, busy_b, done_b, push_b, full_b, wr_b, fc_b);
      model_step(2, 1, 1, 1, busy_c, done_c, push_c, full_c, wr_c, fc_c);
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         full_b = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   task automatic pulse(input int which);
      @(posedge clk);
      #1;
      case (which)
         0: start_a = 1'b1;
         1: start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
   endtask

   task automatic wait_frames(input int k, input int target, input int budget, input string name);
      int t;
      t = 0;
      while (frames[k] < target && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(name, frames[k] >= target, 1'b1);
      @(negedge clk);
   endtask

   initial begin
      int t;
      bit dropped;
      for (int k = 0; k < 3; k++) begin
         idx[k] = 0; frames[k] = 0; pushes[k] = 0;
      end
      repeat (3) @(negedge clk);
      check("reset busy", busy_a, 1'b0);
      check("reset done", done_a, 1'b0);
      check("reset frame_cnt", fc_a, 8'h00);
      check("reset push", push_a | push_b | push_c, 1'b0);
      check("reset wrdata", wr_a, 8'h00);
      check("model pin vert z lo", exp_byte(10, 2, 31, 0), 8'hF0);
      #1 rst = 1'b0;

      // Single 2x1 frame with known literal bytes
      pulse(0);
      wait_frames(0, 1, 200, "a frame1 timeout");
      check("a byte0", cap_a[0], 8'h40);
      check("a byte1", cap_a[1], 8'h00);
      check("a byte2", cap_a[2], 8'hC0);
      check("a byte26", cap_a[26], 8'h86);
      check("a byte27", cap_a[27], 8'h9B);
      check("a byte29", cap_a[29], 8'h01);
      check("a pushes", pushes[0], 56);
      check("a frame_cnt", fc_a, 8'd1);
      check("a busy after", busy_a, 1'b0);

      // start coincident with frame end is ignored
      pulse(0);
      t = 0;
      while (!done_a && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("a done seen", done_a, 1'b1);
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      repeat (3) @(negedge clk);
      check("a start at end ignored busy", busy_a, 1'b0);
      check("a start at end ignored push", push_a, 1'b0);
      check("a frame_cnt 2", fc_a, 8'd2);

      // Full 10x8 Q=2 frame with random back-pressure and a stray start
      stall_en = 1'b1;
      pulse(1);
      repeat (60) @(negedge clk);
      pulse(1);
      wait_frames(1, 1, 20000, "b frame timeout");
      stall_en = 1'b0;
      check("b pushes", pushes[1], 4320);
      check("b frame_cnt", fc_b, 8'd1);
      check("b q1s0 byte0", cap_b[28], 8'hC0);
      check("b q1s0 byte1", cap_b[29], 8'h01);
      check("b q1s0 byte2", cap_b[30], 8'h05);
      check("b q1s0 byte3", cap_b[31], 8'hF0);
      check("b q1s0 byte4", cap_b[32], 8'h01);
      check("b q1s0 byte5", cap_b[33], 8'h00);

      // Looping 1x1 frames
      pulse(2);
      t = 0;
      dropped = 1'b0;
      while (frames[2] < 3 && t < 400) begin
         @(negedge clk);
         if (!busy_c) dropped = 1'b1;
         t++;
      end
      check("c loop timeout", frames[2] >= 3, 1'b1);
      check("c busy held", dropped, 1'b0);
      @(negedge clk);
      check("c frame_cnt 3", fc_c, 8'd3);

      // Reset in the middle of a frame
      pulse(0);
      t = 0;
      while (idx[0] < 13 && t < 100) begin
         @(negedge clk);
         t++;
      end
      #1 rst = 1'b1;
      #1;
      check("midreset push", push_a, 1'b0);
      check("midreset busy", busy_a, 1'b0);
      check("midreset wrdata", wr_a, 8'h00);
      check("midreset done", done_a, 1'b0);
      check("midreset frame_cnt", fc_a, 8'h00);
      check("midreset loop push", push_c, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cap_a[0] = 8'h00;
      pulse(0);
      wait_frames(0, 1, 200, "a restart timeout");
      check("a restart byte0", cap_a[0], 8'h40);
      check("a restart frame_cnt", fc_a, 8'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
